// File: rtl/uart_io_bridge_if.sv
// Processor IO-port bus between a soft CPU (master) and the UART bridge (slave).
interface uart_io_bridge_if;
    logic [7:0] IO_port_ID;
    logic [7:0] IO_write_data;
    logic       IO_write_strobe;
    logic       IO_read_strobe;
    logic [7:0] IO_read_data;

    modport master (
        output IO_port_ID, IO_write_data, IO_write_strobe, IO_read_strobe,
        input  IO_read_data
    );

    modport slave (
        input  IO_port_ID, IO_write_data, IO_write_strobe, IO_read_strobe,
        output IO_read_data
    );
endinterface

// File: rtl/uart_io_bridge.sv
// UART bridge for an 8-bit IO-port processor: TX FIFO + serialiser, RX deserialiser with status flags.
// Define UART_IO_BRIDGE_LOOPBACK_EN to feed the TX serial stream back into the RX path.
module uart_io_bridge #(
    parameter int CLKS_PER_BIT = 868,
    parameter int TX_DEPTH     = 8
) (
    input  logic             clk100,
    input  logic             reset,
    uart_io_bridge_if.slave  io,
    output logic             uart_tx,
    input  logic             uart_rx
);
    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    logic [7:0]    fifo_mem [TX_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          fifo_full, fifo_empty, fifo_push, fifo_pop;

    state_e        tx_state_q, tx_state_d;
    logic [TW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_idx_q, tx_idx_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_q, tx_d;

    logic          rx_src, sync1_q, sync2_q, rx_prev_q, rx_fall;
    state_e        rx_state_q, rx_state_d;
    logic [TW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_idx_q, rx_idx_d;
    logic [7:0]    rx_shift_q, rx_shift_d, rx_hold_q, rx_hold_d;
    logic          rx_present_q, rx_present_d, ovr_q, ovr_d, fe_q, fe_d;
    logic          rx_load, rx_ovr_set, rx_fe_set, rd_data, rd_flags;

`ifdef UART_IO_BRIDGE_LOOPBACK_EN
    logic lb_unused_rx;
    assign lb_unused_rx = uart_rx;
    assign rx_src       = tx_q;
`else
    assign rx_src = uart_rx;
`endif

    assign uart_tx    = tx_q;
    assign fifo_full  = (count_q == CW'(TX_DEPTH));
    assign fifo_empty = (count_q == '0);
    // A full FIFO still accepts a write when the head is leaving on the same edge.
    assign fifo_push  = io.IO_write_strobe && (io.IO_port_ID == 8'h01) && (!fifo_full || fifo_pop);
    assign rd_data    = io.IO_read_strobe && (io.IO_port_ID == 8'h01);
    assign rd_flags   = io.IO_read_strobe && (io.IO_port_ID == 8'h04);
    assign rx_fall    = rx_prev_q && !sync2_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        fifo_pop   = 1'b0;
        case (tx_state_q)
            S_IDLE: if (!fifo_empty) begin
                fifo_pop   = 1'b1;
                tx_state_d = S_START;
                tx_cnt_d   = BIT_LAST;
                tx_shift_d = fifo_mem[rd_ptr_q];
            end
            S_START: if (tx_cnt_q == '0) begin
                tx_state_d = S_DATA;
                tx_cnt_d   = BIT_LAST;
                tx_idx_d   = 3'd0;
            end else tx_cnt_d = tx_cnt_q - TW'(1);
            S_DATA: if (tx_cnt_q == '0) begin
                tx_cnt_d = BIT_LAST;
                if (tx_idx_q == 3'd7) tx_state_d = S_STOP;
                else begin
                    tx_idx_d   = tx_idx_q + 3'd1;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                end
            end else tx_cnt_d = tx_cnt_q - TW'(1);
            S_STOP: if (tx_cnt_q == '0) begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    tx_state_d = S_START;
                    tx_cnt_d   = BIT_LAST;
                    tx_shift_d = fifo_mem[rd_ptr_q];
                end else tx_state_d = S_IDLE;
            end else tx_cnt_d = tx_cnt_q - TW'(1);
            default: tx_state_d = S_IDLE;
        endcase
        tx_d = 1'b1;
        if (tx_state_d == S_START)     tx_d = 1'b0;
        else if (tx_state_d == S_DATA) tx_d = tx_shift_d[0];
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + (fifo_push ? PW'(1) : PW'(0));
        rd_ptr_d = rd_ptr_q + (fifo_pop ? PW'(1) : PW'(0));
        count_d  = count_q;
        if (fifo_push && !fifo_pop)      count_d = count_q + CW'(1);
        else if (!fifo_push && fifo_pop) count_d = count_q - CW'(1);
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_load    = 1'b0;
        rx_ovr_set = 1'b0;
        rx_fe_set  = 1'b0;
        case (rx_state_q)
            S_IDLE: if (rx_fall) begin
                rx_state_d = S_START;
                rx_cnt_d   = HALF_LAST;
            end
            S_START: if (rx_cnt_q == '0) begin
                if (sync2_q) rx_state_d = S_IDLE;
                else begin
                    rx_state_d = S_DATA;
                    rx_cnt_d   = BIT_LAST;
                    rx_idx_d   = 3'd0;
                end
            end else rx_cnt_d = rx_cnt_q - TW'(1);
            S_DATA: if (rx_cnt_q == '0) begin
                rx_shift_d = {sync2_q, rx_shift_q[7:1]};
                rx_cnt_d   = BIT_LAST;
                if (rx_idx_q == 3'd7) rx_state_d = S_STOP;
                else rx_idx_d = rx_idx_q + 3'd1;
            end else rx_cnt_d = rx_cnt_q - TW'(1);
            S_STOP: if (rx_cnt_q == '0) begin
                rx_state_d = S_IDLE;
                if (!sync2_q)          rx_fe_set  = 1'b1;
                else if (rx_present_q) rx_ovr_set = 1'b1;
                else                   rx_load    = 1'b1;
            end else rx_cnt_d = rx_cnt_q - TW'(1);
            default: rx_state_d = S_IDLE;
        endcase
    end

    // Setting events win over the processor's clear-on-read.
    assign rx_hold_d    = rx_load ? rx_shift_q : rx_hold_q;
    assign rx_present_d = rx_load || (rx_present_q && !rd_data);
    assign ovr_d        = rx_ovr_set || (ovr_q && !rd_flags);
    assign fe_d         = rx_fe_set || (fe_q && !rd_flags);

    always_comb begin
        case (io.IO_port_ID)
            8'h01:   io.IO_read_data = rx_hold_q;
            8'h02:   io.IO_read_data = {8{rx_present_q}};
            8'h03:   io.IO_read_data = {8{fifo_full}};
            8'h04:   io.IO_read_data = {6'b0, fe_q, ovr_q};
            default: io.IO_read_data = 8'hFF;
        endcase
    end

    always_ff @(posedge clk100) begin
        if (fifo_push && !reset) fifo_mem[wr_ptr_q] <= io.IO_write_data;
    end

    always_ff @(posedge clk100) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            tx_state_q   <= S_IDLE;
            tx_cnt_q     <= '0;
            tx_idx_q     <= '0;
            tx_shift_q   <= '0;
            tx_q         <= 1'b1;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= S_IDLE;
            rx_cnt_q     <= '0;
            rx_idx_q     <= '0;
            rx_shift_q   <= '0;
            rx_hold_q    <= '0;
            rx_present_q <= 1'b0;
            ovr_q        <= 1'b0;
            fe_q         <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_idx_q     <= tx_idx_d;
            tx_shift_q   <= tx_shift_d;
            tx_q         <= tx_d;
            sync1_q      <= rx_src;
            sync2_q      <= sync1_q;
            rx_prev_q    <= sync2_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_idx_q     <= rx_idx_d;
            rx_shift_q   <= rx_shift_d;
            rx_hold_q    <= rx_hold_d;
            rx_present_q <= rx_present_d;
            ovr_q        <= ovr_d;
            fe_q         <= fe_d;
        end
    end
endmodule

// File: tb/tb_uart_io_bridge.sv
// Bench for uart_io_bridge: line-level TX decoder, byte-level RX status model, directed scenarios.
`timescale 1ns/1ps
module tb_uart_io_bridge;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;

    logic clk100 = 1'b0;
    logic reset;
    logic uart_tx;
    logic uart_rx;

    uart_io_bridge_if bus();

    uart_io_bridge #(.CLKS_PER_BIT(CPB), .TX_DEPTH(DEPTH)) dut (
        .clk100  (clk100),
        .reset   (reset),
        .io      (bus),
        .uart_tx (uart_tx),
        .uart_rx (uart_rx)
    );

    always #5 clk100 = ~clk100;

    int n_vec = 0;
    int n_err = 0;

    // RX status model: what the processor must see, byte by byte.
    logic [7:0] m_hold;
    logic       m_present, m_ovr, m_fe;
    logic       chk_en;

    // TX line model: bytes that must appear on uart_tx, in order.
    logic [7:0] tx_exp[$];
    logic       gap_check;
    logic       mon_active, mon_ignore;
    int         mon_pos, mon_bit, idle_run;
    logic [7:0] mon_byte;
    logic       mon_exp;
    logic [9:0] a5_line;

    function automatic void check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h, required %02h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, required %b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] id);
        case (id)
            8'h01:   return m_hold;
            8'h02:   return m_present ? 8'hFF : 8'h00;
            8'h04:   return {6'b0, m_fe, m_ovr};
            default: return 8'hFF;
        endcase
    endfunction

    function automatic void model_frame(input logic [7:0] d, input logic stop);
        if (!stop)          m_fe = 1'b1;
        else if (m_present) m_ovr = 1'b1;
        else begin
            m_hold    = d;
            m_present = 1'b1;
        end
    endfunction

    function automatic void model_reset();
        m_hold    = 8'h00;
        m_present = 1'b0;
        m_ovr     = 1'b0;
        m_fe      = 1'b0;
    endfunction

    // Read-port compare against the model (port 0x03 is checked explicitly).
    always @(negedge clk100) begin
        if (chk_en && !reset && bus.IO_port_ID != 8'h03)
            check8("rd_model", bus.IO_read_data, model_read(bus.IO_port_ID));
    end

    // Serial line decoder: every cycle of every frame must match the next expected byte.
    always @(negedge clk100) begin
        if (reset) begin
            mon_active = 1'b0;
            mon_pos    = 0;
        end else if (!mon_active) begin
            if (uart_tx !== 1'b1) begin
                mon_active = 1'b1;
                mon_pos    = 1;
                if (tx_exp.size() == 0) begin
                    mon_ignore = 1'b1;
                    n_vec++;
                    n_err++;
                    $display("FAIL tx_unexpected: got start bit at %0t, required idle line", $time);
                end else begin
                    mon_ignore = 1'b0;
                    mon_byte   = tx_exp.pop_front();
                    if (gap_check) begin
                        n_vec++;
                        if (idle_run != 0) begin
                            n_err++;
                            $display("FAIL tx_gap: got %0d idle cycles, required 0", idle_run);
                        end
                    end
                end
            end else idle_run++;
        end else begin
            mon_bit = mon_pos / CPB;
            mon_exp = (mon_bit == 0) ? 1'b0 : (mon_bit == 9) ? 1'b1 : mon_byte[mon_bit - 1];
            if (!mon_ignore) check1("tx_line", uart_tx, mon_exp);
            mon_pos++;
            if (mon_pos == 10 * CPB) begin
                mon_active = 1'b0;
                idle_run   = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic check_rd(input string name, input logic [7:0] id, input logic [7:0] exp);
        tick();
        bus.IO_port_ID = id;
        @(negedge clk100);
        check8(name, bus.IO_read_data, exp);
    endtask

    task automatic io_write(input logic [7:0] id, input logic [7:0] d);
        tick();
        bus.IO_port_ID      = id;
        bus.IO_write_data   = d;
        bus.IO_write_strobe = 1'b1;
        tick();
        bus.IO_write_strobe = 1'b0;
    endtask

    task automatic io_read(input logic [7:0] id);
        tick();
        bus.IO_port_ID     = id;
        bus.IO_read_strobe = 1'b1;
        tick();
        bus.IO_read_strobe = 1'b0;
        if (id == 8'h01) m_present = 1'b0;
        if (id == 8'h04) begin
            m_ovr = 1'b0;
            m_fe  = 1'b0;
        end
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = fr[i];
            repeat (CPB) tick();
        end
        uart_rx = 1'b1;
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stop);
        chk_en = 1'b0;
        send_rx(d, stop);
        repeat (6) tick();
        model_frame(d, stop);
        chk_en = 1'b1;
    endtask

    task automatic reset_mid_frame();
        tx_exp.push_back(8'h00);
        io_write(8'h01, 8'h00);
        repeat (12) tick();
        @(negedge clk100);
        check1("mid_frame_low", uart_tx, 1'b0);
        tick();
        reset = 1'b1;
        model_reset();
        tick();
        @(negedge clk100);
        check1("reset_mid_tx", uart_tx, 1'b1);
        tick();
        reset = 1'b0;
        repeat (50) tick();
        check_rd("reset_mid_p2", 8'h02, 8'h00);
        check1("reset_mid_idle", uart_tx, 1'b1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout, required end of test");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int guard;
        int waited;
        reset               = 1'b1;
        uart_rx             = 1'b1;
        bus.IO_port_ID      = 8'h00;
        bus.IO_write_data   = 8'h00;
        bus.IO_write_strobe = 1'b0;
        bus.IO_read_strobe  = 1'b0;
        chk_en              = 1'b0;
        gap_check           = 1'b0;
        mon_active          = 1'b0;
        mon_ignore          = 1'b0;
        idle_run            = 0;
        model_reset();
        repeat (3) tick();
        reset = 1'b0;

        @(negedge clk100);
        check1("rst_tx", uart_tx, 1'b1);
        check_rd("rst_p1", 8'h01, 8'h00);
        check_rd("rst_p2", 8'h02, 8'h00);
        check_rd("rst_p3", 8'h03, 8'h00);
        check_rd("rst_p4", 8'h04, 8'h00);
        check_rd("rst_other", 8'h7E, 8'hFF);

`ifndef UART_IO_BRIDGE_LOOPBACK_EN
        chk_en = 1'b1;

        // Single frame, cycle-exact waveform.
        a5_line = 10'b1_10100101_0;
        tx_exp.push_back(8'hA5);
        io_write(8'h01, 8'hA5);
        @(negedge clk100);
        check1("a5_lead", uart_tx, 1'b1);
        for (int k = 0; k < 10 * CPB; k++) begin
            @(negedge clk100);
            check1("a5_line", uart_tx, a5_line[k / CPB]);
        end
        @(negedge clk100);
        check1("a5_idle", uart_tx, 1'b1);

        // Writes to other ports never reach the line.
        io_write(8'h02, 8'h77);
        io_write(8'h00, 8'h66);
        repeat (20) tick();
        check1("other_port_idle", uart_tx, 1'b1);

        // Burst while busy: eight fill the FIFO, the ninth (0x08) is dropped.
        tx_exp.push_back(8'hE7);
        io_write(8'h01, 8'hE7);
        repeat (2) tick();
        for (int i = 0; i < 8; i++) tx_exp.push_back(8'(i));
        bus.IO_port_ID      = 8'h01;
        bus.IO_write_strobe = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.IO_write_data = 8'(i);
            tick();
        end
        bus.IO_write_strobe = 1'b0;
        check_rd("burst_full", 8'h03, 8'hFF);
        gap_check = 1'b1;
        guard = 0;
        while ((tx_exp.size() != 0 || mon_active) && guard < 1000) begin
            tick();
            guard++;
        end
        n_vec++;
        if (guard >= 1000) begin
            n_err++;
            $display("FAIL burst_drain: got %0d bytes pending, required 0", tx_exp.size());
        end
        gap_check = 1'b0;
        check_rd("burst_not_full", 8'h03, 8'h00);
        repeat (60) tick();

        // Single received byte, then clear-on-read.
        bus.IO_port_ID = 8'h02;
        rx_frame(8'h3C, 1'b1);
        check_rd("rx_present", 8'h02, 8'hFF);
        check_rd("rx_data", 8'h01, 8'h3C);
        io_read(8'h01);
        check_rd("rx_cleared", 8'h02, 8'h00);

        // Overrun keeps the first byte.
        rx_frame(8'h11, 1'b1);
        rx_frame(8'h22, 1'b1);
        check_rd("ovr_data", 8'h01, 8'h11);
        check_rd("ovr_flag", 8'h04, 8'h01);
        io_read(8'h04);
        check_rd("ovr_clear", 8'h04, 8'h00);
        io_read(8'h01);
        check_rd("ovr_p2_clear", 8'h02, 8'h00);

        // Framing error, then a short glitch that must not start a frame.
        rx_frame(8'h55, 1'b0);
        check_rd("fe_flag", 8'h04, 8'h02);
        check_rd("fe_nodata", 8'h02, 8'h00);
        repeat (8) tick();
        uart_rx = 1'b0;
        repeat (2) tick();
        uart_rx = 1'b1;
        repeat (60) tick();
        check_rd("glitch_flag", 8'h04, 8'h02);
        check_rd("glitch_nodata", 8'h02, 8'h00);
        rx_frame(8'h96, 1'b1);
        check_rd("post_glitch_data", 8'h01, 8'h96);
        check_rd("post_glitch_p2", 8'h02, 8'hFF);
        io_read(8'h04);
        io_read(8'h01);
        check_rd("final_p4", 8'h04, 8'h00);
        check_rd("other_id", 8'h05, 8'hFF);

        reset_mid_frame();
`else
        // Loopback: the transmitted byte comes back through the RX path.
        tx_exp.push_back(8'h5A);
        io_write(8'h01, 8'h5A);
        bus.IO_port_ID = 8'h02;
        waited = 0;
        for (int c = 1; c <= 10 * CPB + 4; c++) begin
            tick();
            waited = c;
            if (bus.IO_read_data == 8'hFF) break;
        end
        check8("lb_present", bus.IO_read_data, 8'hFF);
        n_vec++;
        if (waited > 10 * CPB + 4) begin
            n_err++;
            $display("FAIL lb_latency: got %0d cycles, required <= %0d", waited, 10 * CPB + 4);
        end
        check_rd("lb_data", 8'h01, 8'h5A);
        check_rd("lb_flags", 8'h04, 8'h00);
        io_read(8'h01);
        check_rd("lb_cleared", 8'h02, 8'h00);
        repeat (20) tick();
        reset_mid_frame();
`endif

        repeat (20) tick();
        n_vec++;
        if (tx_exp.size() != 0 || mon_active) begin
            n_err++;
            $display("FAIL tx_leftover: got %0d bytes pending, required 0", tx_exp.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
